// File: rtl/fbcpu_mem_checker.sv
// +----------------------------------------------------------------------------+
// | fbcpu_mem_checker                                                          |
// | End-of-run RAM checker: holds FBCPU for a run window, then compares a      |
// | programmable table of (address, expected) entries against RAM contents.    |
// | Optional: `FBCPU_HALT_DETECT_EN ends the run early when pc stops moving.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module fbcpu_mem_checker #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10,
   parameter int NUM_CHECKS    = 4,
   parameter int RUN_CYCLES    = 10000,
   parameter int CNT_WIDTH     = 16,
   parameter int READ_LATENCY  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     cfg_we,
   input  logic [3:0]               cfg_idx,
   input  logic                     cfg_valid,
   input  logic [ADDRESS_WIDTH-1:0] cfg_addr,
   input  logic [DATA_WIDTH-1:0]    cfg_data,
   input  logic [ADDRESS_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
`ifdef FBCPU_HALT_DETECT_EN
   output logic                     early_halt,
`endif
   output logic                     cpu_hold,
   output logic                     mem_sel,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [4:0]               fail_count,
   output logic [3:0]               first_fail_idx,
   output logic [DATA_WIDTH-1:0]    first_fail_data
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_READ = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_RUN_LAST  = CNT_WIDTH'(RUN_CYCLES - 1);
   localparam logic [3:0]           c_IDX_LAST  = 4'(NUM_CHECKS - 1);
   localparam logic [1:0]           c_WAIT_LAST = 2'(READ_LATENCY);
   localparam logic [4:0]           c_NUM       = 5'(NUM_CHECKS);

   state_t                   r_state, w_nextState;
   logic [CNT_WIDTH-1:0]     r_runCnt;
   logic [3:0]               r_idx;
   logic [1:0]               r_waitCnt;
   logic [4:0]               r_failCount;
   logic [3:0]               r_firstIdx;
   logic [DATA_WIDTH-1:0]    r_firstData;

   // Tables are 16 deep so the 4-bit index never overruns; unused rows stay invalid.
   logic                     r_validTab [16];
   logic [ADDRESS_WIDTH-1:0] r_addrTab  [16];
   logic [DATA_WIDTH-1:0]    r_expTab   [16];

   logic w_startOk, w_cfgOk, w_halt, w_runEnd, w_waitLast, w_idxLast;

   assign w_startOk  = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_cfgOk    = cfg_we && (r_state == S_IDLE || r_state == S_DONE)
                       && ({1'b0, cfg_idx} < c_NUM);
   assign w_runEnd   = (r_state == S_RUN) && ((r_runCnt == c_RUN_LAST) || w_halt);
   assign w_waitLast = (r_waitCnt == c_WAIT_LAST);
   assign w_idxLast  = (r_idx == c_IDX_LAST);

`ifdef FBCPU_HALT_DETECT_EN
   logic [ADDRESS_WIDTH-1:0] r_prevPc;
   logic [3:0]               r_haltCnt;
   logic                     r_earlyHalt;
   logic                     w_pcSame;

   // 15 back-to-back repeats means pc has held one value for 16 cycles.
   assign w_pcSame   = (pc == r_prevPc);
   assign w_halt     = (r_state == S_RUN) && w_pcSame && (r_haltCnt == 4'd14);
   assign early_halt = r_earlyHalt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prevPc    <= '0;
         r_haltCnt   <= '0;
         r_earlyHalt <= 1'b0;
      end else begin
         r_prevPc <= pc;
         if (w_startOk) begin
            r_haltCnt   <= '0;
            r_earlyHalt <= 1'b0;
         end else if (r_state == S_RUN) begin
            if (!w_pcSame)                r_haltCnt <= '0;
            else if (r_haltCnt != 4'd15)  r_haltCnt <= r_haltCnt + 4'd1;
            if (w_halt)                   r_earlyHalt <= 1'b1;
         end
      end
   end
`else
   logic w_unusedPc;
   assign w_unusedPc = ^pc;
   assign w_halt     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      cpu_hold    = 1'b1;
      mem_sel     = 1'b0;
      mem_addr    = '0;
      busy        = 1'b0;
      done        = 1'b0;
      pass        = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_nextState = S_RUN;
         S_RUN: begin
            cpu_hold = 1'b0;
            busy     = 1'b1;
            if (w_runEnd) w_nextState = S_READ;
         end
         S_READ: begin
            busy = 1'b1;
            if (r_validTab[r_idx]) begin
               mem_sel     = 1'b1;
               mem_addr    = r_addrTab[r_idx];
               w_nextState = S_WAIT;
            end else if (w_idxLast) begin
               w_nextState = S_DONE;
            end
         end
         S_WAIT: begin
            busy     = 1'b1;
            mem_sel  = 1'b1;
            mem_addr = r_addrTab[r_idx];
            if (w_waitLast) w_nextState = w_idxLast ? S_DONE : S_READ;
         end
         S_DONE: begin
            done = 1'b1;
            pass = (r_failCount == 5'd0);
            if (start) w_nextState = S_RUN;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_runCnt    <= '0;
         r_idx       <= '0;
         r_waitCnt   <= '0;
         r_failCount <= '0;
         r_firstIdx  <= '0;
         r_firstData <= '0;
         for (int i = 0; i < 16; i++) begin
            r_validTab[i] <= 1'b0;
            r_addrTab[i]  <= '0;
            r_expTab[i]   <= '0;
         end
      end else begin
         if (w_cfgOk) begin
            r_validTab[cfg_idx] <= cfg_valid;
            r_addrTab[cfg_idx]  <= cfg_addr;
            r_expTab[cfg_idx]   <= cfg_data;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_runCnt    <= '0;
                  r_idx       <= '0;
                  r_failCount <= '0;
                  r_firstIdx  <= '0;
                  r_firstData <= '0;
               end
            end
            S_RUN: r_runCnt <= r_runCnt + 1'b1;
            S_READ: begin
               if (r_validTab[r_idx]) r_waitCnt <= 2'd1;
               else if (!w_idxLast)   r_idx     <= r_idx + 4'd1;
            end
            S_WAIT: begin
               r_waitCnt <= r_waitCnt + 2'd1;
               if (w_waitLast) begin
                  // Written as if/else so an unknown compare lands on the mismatch path.
                  if (mem_rdata == r_expTab[r_idx]) begin
                  end else begin
                     if (r_failCount == 5'd0) begin
                        r_firstIdx  <= r_idx;
                        r_firstData <= mem_rdata;
                     end
                     if (r_failCount != 5'd31) r_failCount <= r_failCount + 5'd1;
                  end
                  if (!w_idxLast) r_idx <= r_idx + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign fail_count      = r_failCount;
   assign first_fail_idx  = r_firstIdx;
   assign first_fail_data = r_firstData;

endmodule

`default_nettype wire

// File: tb/tb_fbcpu_mem_checker.sv
// +----------------------------------------------------------------------------+
// | tb_fbcpu_mem_checker                                                       |
// | Randomised self-checking bench with a behavioural RAM and checker model.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fbcpu_mem_checker;

   localparam int AW = 6;
   localparam int DW = 10;
   localparam int NC = 4;
   localparam int RC = 40;
   localparam int CW = 16;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          cfg_we = 1'b0;
   logic [3:0]    cfg_idx = '0;
   logic          cfg_valid = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [DW-1:0] cfg_data = '0;
   logic [AW-1:0] pc = '0;
   logic [DW-1:0] mem_rdata;
   logic          cpu_hold, mem_sel, busy, done, pass;
   logic [AW-1:0] mem_addr;
   logic [4:0]    fail_count;
   logic [3:0]    first_fail_idx;
   logic [DW-1:0] first_fail_data;
`ifdef FBCPU_HALT_DETECT_EN
   logic          early_halt;
`endif

   int nChecks = 0;
   int nFails  = 0;
   bit pcFreeze = 1'b0;

   logic [DW-1:0] ram [64];
   logic [DW-1:0] rdPipe [RL];
   logic [AW-1:0] ramAddr;

   bit            mValid [NC];
   logic [AW-1:0] mAddr  [NC];
   logic [DW-1:0] mExp   [NC];

   fbcpu_mem_checker #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CHECKS(NC),
      .RUN_CYCLES(RC), .CNT_WIDTH(CW), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .pc(pc), .mem_rdata(mem_rdata),
`ifdef FBCPU_HALT_DETECT_EN
      .early_halt(early_halt),
`endif
      .cpu_hold(cpu_hold), .mem_sel(mem_sel), .mem_addr(mem_addr), .busy(busy),
      .done(done), .pass(pass), .fail_count(fail_count),
      .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data)
   );

   always #5 clk = ~clk;

   // Stand-in for the CPU: pc keeps moving unless a halt loop is being modelled.
   always @(negedge clk) pc = pcFreeze ? AW'(12) : pc + 1'b1;

   // RAM with READ_LATENCY cycles from address to data.
   assign ramAddr   = mem_sel ? mem_addr : pc;
   assign mem_rdata = rdPipe[RL-1];
   always @(posedge clk) begin
      rdPipe[0] <= ram[ramAddr];
      for (int k = 1; k < RL; k++) rdPipe[k] <= rdPipe[k-1];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cfgWrite(input int idx, input bit v, input int a, input int d);
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_idx   = 4'(idx);
      cfg_valid = v;
      cfg_addr  = AW'(a);
      cfg_data  = DW'(d);
      @(negedge clk);
      cfg_we = 1'b0;
      if (idx < NC) begin
         mValid[idx] = v;
         mAddr[idx]  = AW'(a);
         mExp[idx]   = DW'(d);
      end
   endtask

   // Expected outcome of one run: every enabled entry costs 1+RL, a skipped one 1,
   // and the count includes the edge that accepts start.
   task automatic modelEval(output int fc, output int fi, output int fd,
                            output int cyc, output int sel);
      fc = 0; fi = 0; fd = 0; cyc = RC + 1; sel = 0;
      for (int i = 0; i < NC; i++) begin
         if (mValid[i]) begin
            cyc += 1 + RL;
            sel += 1 + RL;
            if (ram[mAddr[i]] != mExp[i]) begin
               if (fc == 0) begin
                  fi = i;
                  fd = int'(ram[mAddr[i]]);
               end
               if (fc < 31) fc++;
            end
         end else begin
            cyc += 1;
         end
      end
   endtask

   task automatic runSeq(input string name, input bit inject);
      int eFc, eFi, eFd, eCyc, eSel;
      int cyc = 0, holdLow = 0, selHi = 0;
      bit seen = 1'b0, injCfg = 1'b0;
      modelEval(eFc, eFi, eFd, eCyc, eSel);
      @(negedge clk);
      start = 1'b1;
      while (!seen && cyc < RC + NC * (RL + 1) + 20) begin
         @(negedge clk);
         start  = 1'b0;
         cfg_we = 1'b0;
         cyc++;
         if (!cpu_hold) holdLow++;
         if (mem_sel)   selHi++;
         if (cyc == 2) check({name, ".busy_run"}, busy, 1);
         if (done) seen = 1'b1;
         else if (inject) begin
            if (cyc == 5) start = 1'b1;
            if (mem_sel && !injCfg) begin
               injCfg    = 1'b1;
               cfg_we    = 1'b1;
               cfg_idx   = 4'd3;
               cfg_valid = ~mValid[3];
               cfg_addr  = mAddr[3] + 1'b1;
               cfg_data  = ~mExp[3];
            end
         end
      end
      start  = 1'b0;
      cfg_we = 1'b0;
      check({name, ".done"},      done, 1);
      check({name, ".cycles"},    cyc, eCyc);
      check({name, ".hold_low"},  holdLow, RC);
      check({name, ".sel_cyc"},   selHi, eSel);
      check({name, ".pass"},      pass, (eFc == 0));
      check({name, ".fail_cnt"},  fail_count, eFc);
      check({name, ".ff_idx"},    first_fail_idx, eFi);
      check({name, ".ff_data"},   first_fail_data, eFd);
      check({name, ".busy_done"}, busy, 0);
      check({name, ".hold_done"}, cpu_hold, 1);
`ifdef FBCPU_HALT_DETECT_EN
      check({name, ".early"},     early_halt, 0);
`endif
   endtask

   task automatic checkResetOutputs(input string name);
      check({name, ".cpu_hold"}, cpu_hold, 1);
      check({name, ".mem_sel"},  mem_sel, 0);
      check({name, ".mem_addr"}, mem_addr, 0);
      check({name, ".busy"},     busy, 0);
      check({name, ".done"},     done, 0);
      check({name, ".pass"},     pass, 0);
      check({name, ".fail_cnt"}, fail_count, 0);
      check({name, ".ff_idx"},   first_fail_idx, 0);
      check({name, ".ff_data"},  first_fail_data, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = DW'($urandom);
      for (int i = 0; i < NC; i++) begin
         mValid[i] = 1'b0; mAddr[i] = '0; mExp[i] = '0;
      end

      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b1;

      ram[52] = DW'(15);
      cfgWrite(0, 1, 52, 15);
      runSeq("single", 0);

      ram[10] = DW'(50); ram[11] = DW'(8); ram[12] = DW'(9); ram[13] = DW'(2);
      cfgWrite(0, 1, 10, 50); cfgWrite(1, 1, 11, 7);
      cfgWrite(2, 1, 12, 9);  cfgWrite(3, 1, 13, 1);
      runSeq("mixed", 0);
      check("mixed.fc_abs",  fail_count, 2);
      check("mixed.ffi_abs", first_fail_idx, 1);
      check("mixed.ffd_abs", first_fail_data, 8);

      for (int i = 0; i < NC; i++) cfgWrite(i, 0, i, 0);
      cfgWrite(7, 1, 3, 3);
      runSeq("none", 0);

      cfgWrite(0, 1, 10, 50); cfgWrite(1, 1, 11, 7);
      cfgWrite(2, 1, 12, 9);  cfgWrite(3, 1, 13, 1);
      runSeq("inject", 1);
      ram[11] = DW'(7); ram[13] = DW'(1);
      runSeq("rerun", 0);

      // Reset while an entry read is in flight.
      for (int i = 1; i < NC; i++) cfgWrite(i, 0, 0, 0);
      ram[20] = DW'(5);
      cfgWrite(0, 1, 20, 5);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < RC + 20 && !mem_sel; k++) @(negedge clk);
      check("rstw.sel_seen", mem_sel, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkResetOutputs("rstw");
      for (int i = 0; i < NC; i++) mValid[i] = 1'b0;
      @(negedge clk); rst = 1'b1;
      runSeq("after_rst", 0);
      cfgWrite(1, 1, 20, 5);
      runSeq("reprog", 0);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NC; i++) begin
            int a, d;
            a = $urandom_range(0, 63);
            d = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) ram[a] = DW'(d);
            cfgWrite(i, ($urandom_range(0, 3) != 0), a, d);
         end
         runSeq($sformatf("rand%0d", r), r[0]);
      end

`ifdef FBCPU_HALT_DETECT_EN
      begin
         int cyc = 0, holdLow = 0;
         pcFreeze = 1'b1;
         @(negedge clk); start = 1'b1;
         while (!done && cyc < RC + 40) begin
            @(negedge clk); start = 1'b0; cyc++;
            if (!cpu_hold) holdLow++;
         end
         check("halt.done",   done, 1);
         check("halt.early",  early_halt, 1);
         check("halt.window", (holdLow >= 14 && holdLow <= 18), 1);
         pcFreeze = 1'b0;
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule

`default_nettype wire
